// File: rtl/mmio_unit_if.sv
// Core data-bus side of the MMIO peripheral block: address, store data, strobes,
// plus the combinational hit/read-data return path.
interface mmio_unit_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              re;
  logic              hit;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr,
    output wdata,
    output we,
    output re,
    input  hit,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    input  re,
    output hit,
    output rdata
  );

endinterface

// File: rtl/mmio_unit.sv
// Memory-mapped peripheral block: output registers, valid/ready input channels and a loadable
// cycle counter with compare match. Define MMIO_IRQ_EN to map IE and drive irq.
module mmio_unit #(
  parameter int unsigned DATA_W = 32,
  parameter logic [31:0] BASE   = 32'h7f00,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned N_IN   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  mmio_unit_if.slave              bus,
  output logic [N_OUT*DATA_W-1:0] out_bus,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  input  logic [N_IN-1:0]         in_vld,
  output logic [N_IN-1:0]         in_rdy,
  output logic [DATA_W-1:0]       cycles,
  output logic                    irq
);

  localparam logic [4:0] IdxCycle  = 5'd8;
  localparam logic [4:0] IdxCmp    = 5'd9;
  localparam logic [4:0] IdxStatus = 5'd10;
  localparam logic [4:0] IdxIe     = 5'd11;
  localparam int unsigned IdxInBase = 16;

  // Address decode: addresses below BASE wrap to large offsets and fall outside the window.
  logic [31:0] off;
  logic        in_win;
  logic [4:0]  widx;
  logic        unused_addr_bits;

  assign off              = bus.addr - BASE;
  assign in_win           = (off < 32'h80);
  assign widx             = off[6:2];
  assign unused_addr_bits = ^off[1:0];

  logic [N_OUT-1:0] sel_out;
  logic [N_IN-1:0]  sel_in;
  logic             sel_cycle;
  logic             sel_cmp;
  logic             sel_status;
  logic             sel_ie;

  always_comb begin
    sel_out = '0;
    sel_in  = '0;
    for (int k = 0; k < N_OUT; k++) begin
      sel_out[k] = in_win && (widx == 5'(k));
    end
    for (int k = 0; k < N_IN; k++) begin
      sel_in[k] = in_win && (widx == 5'(IdxInBase + k));
    end
    sel_cycle  = in_win && (widx == IdxCycle);
    sel_cmp    = in_win && (widx == IdxCmp);
    sel_status = in_win && (widx == IdxStatus);
`ifdef MMIO_IRQ_EN
    sel_ie     = in_win && (widx == IdxIe);
`else
    sel_ie     = 1'b0;
`endif
  end

  assign bus.hit = (|sel_out) | (|sel_in) | sel_cycle | sel_cmp | sel_status | sel_ie;

  logic wr;
  assign wr = bus.we & bus.hit;

  // State
  logic [DATA_W-1:0] out_q [N_OUT];
  logic [DATA_W-1:0] out_d [N_OUT];
  logic [DATA_W-1:0] in_q  [N_IN];
  logic [DATA_W-1:0] in_d  [N_IN];
  logic [N_IN-1:0]   full_q;
  logic [N_IN-1:0]   full_d;
  logic [DATA_W-1:0] cycle_q;
  logic [DATA_W-1:0] cycle_d;
  logic [DATA_W-1:0] cmp_q;
  logic [DATA_W-1:0] cmp_d;
  logic              match_q;
  logic              match_d;
  logic              ie_bit;

`ifdef MMIO_IRQ_EN
  logic ie_q;
  logic ie_d;

  always_comb begin
    ie_d = ie_q;
    if (wr && sel_ie) begin
      ie_d = bus.wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q <= 1'b0;
    end else begin
      ie_q <= ie_d;
    end
  end

  assign ie_bit = ie_q;
  assign irq    = ie_q & (match_q | (|full_q));
`else
  assign ie_bit = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      out_d[k] = (wr && sel_out[k]) ? bus.wdata : out_q[k];
    end

    // A store to CYCLE takes priority over the free-running increment.
    cycle_d = (wr && sel_cycle) ? bus.wdata : cycle_q + DATA_W'(1);
    cmp_d   = (wr && sel_cmp) ? bus.wdata : cmp_q;

    // Compare uses the pre-edge count; a simultaneous W1C loses to the set.
    match_d = match_q;
    if (wr && sel_status && bus.wdata[0]) begin
      match_d = 1'b0;
    end
    if (cycle_q == cmp_q) begin
      match_d = 1'b1;
    end

    for (int k = 0; k < N_IN; k++) begin
      in_d[k]   = in_q[k];
      full_d[k] = full_q[k];
      if (in_vld[k] && !full_q[k]) begin
        in_d[k]   = in_data[k*DATA_W +: DATA_W];
        full_d[k] = 1'b1;
      end else if (bus.re && sel_in[k]) begin
        full_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) begin
        out_q[k] <= '0;
      end
      for (int k = 0; k < N_IN; k++) begin
        in_q[k] <= '0;
      end
      full_q  <= '0;
      cycle_q <= '0;
      cmp_q   <= '1;
      match_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        out_q[k] <= out_d[k];
      end
      for (int k = 0; k < N_IN; k++) begin
        in_q[k] <= in_d[k];
      end
      full_q  <= full_d;
      cycle_q <= cycle_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  // Read mux; unmapped addresses leave rdata at zero.
  always_comb begin
    bus.rdata = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (sel_out[k]) begin
        bus.rdata = out_q[k];
      end
    end
    for (int k = 0; k < N_IN; k++) begin
      if (sel_in[k]) begin
        bus.rdata = in_q[k];
      end
    end
    if (sel_cycle) begin
      bus.rdata = cycle_q;
    end
    if (sel_cmp) begin
      bus.rdata = cmp_q;
    end
    if (sel_status) begin
      bus.rdata = DATA_W'({full_q, match_q});
    end
    if (sel_ie) begin
      bus.rdata = DATA_W'(ie_bit);
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out_bus
    assign out_bus[k*DATA_W +: DATA_W] = out_q[k];
  end

  assign in_rdy = ~full_q;
  assign cycles = cycle_q;

endmodule

// File: tb/tb_mmio_unit.sv
// Directed bench for mmio_unit (DATA_W=32, BASE=0x7f00, N_OUT=2, N_IN=2); inputs change and
// outputs are sampled on the falling clock edge.
module tb_mmio_unit;

  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] out_bus;
  logic [63:0] in_data;
  logic [1:0]  in_vld;
  logic [1:0]  in_rdy;
  logic [31:0] cycles;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_unit_if #(.DATA_W(DW)) bus_if ();

  mmio_unit #(
    .DATA_W(DW),
    .BASE  (32'h7f00),
    .N_OUT (2),
    .N_IN  (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if),
    .out_bus(out_bus),
    .in_data(in_data),
    .in_vld (in_vld),
    .in_rdy (in_rdy),
    .cycles (cycles),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    bus_if.addr  = a;
    bus_if.wdata = d;
    bus_if.we    = w;
    bus_if.re    = r;
    #1;
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(a, 32'h0, 1'b0, 1'b0);
    check(tag, 64'(bus_if.rdata), 64'(exp));
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  logic exp_ie;

  initial begin
`ifdef MMIO_IRQ_EN
    exp_ie = 1'b1;
`else
    exp_ie = 1'b0;
`endif
    rst     = 1'b1;
    in_vld  = '0;
    in_data = '0;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    nxt;
    nxt;
    rst = 1'b0;

    // Reset state
    peek("status_rst", 32'h7f28, 32'h0);
    check("hit_status", 64'(bus_if.hit), 64'd1);
    peek("cmp_rst", 32'h7f24, 32'hffff_ffff);
    check("in_rdy_rst", 64'(in_rdy), 64'h3);
    check("out_bus_rst", out_bus, 64'h0);
    check("irq_rst", 64'(irq), 64'h0);
    check("cycles_rst", 64'(cycles), 64'h0);

    // Output registers and decode boundaries
    drive(32'h7f04, 32'h5, 1'b1, 1'b0);
    check("hit_out1", 64'(bus_if.hit), 64'd1);
    nxt;
    check("out_bus_wr", out_bus, 64'h0000_0005_0000_0000);
    peek("out2_oob", 32'h7f08, 32'h0);
    check("hit_out2", 64'(bus_if.hit), 64'd0);
    peek("in2_oob", 32'h7f48, 32'h0);
    check("hit_in2", 64'(bus_if.hit), 64'd0);
    peek("win_end", 32'h7f80, 32'h0);
    check("hit_win_end", 64'(bus_if.hit), 64'd0);
    peek("out1_rd", 32'h7f04, 32'h5);
    drive(32'h7f08, 32'hdead, 1'b1, 1'b0);
    nxt;
    check("out_bus_oob_wr", out_bus, 64'h0000_0005_0000_0000);

    // Cycle counter load and wrap (reset CMP is all-ones, so the wrap also sets MATCH)
    drive(32'h7f20, 32'hffff_fffe, 1'b1, 1'b0);
    nxt;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("cyc_load", 64'(cycles), 64'hffff_fffe);
    nxt;
    check("cyc_max", 64'(cycles), 64'hffff_ffff);
    nxt;
    check("cyc_wrap", 64'(cycles), 64'h0);
    peek("match_wrap", 32'h7f28, 32'h1);
    drive(32'h7f20, 32'h100, 1'b1, 1'b0);
    nxt;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("cyc_load2", 64'(cycles), 64'h100);
    nxt;
    check("cyc_inc", 64'(cycles), 64'h101);

    // MATCH: clear, then CMP=10 and CYCLE=8
    drive(32'h7f28, 32'h1, 1'b1, 1'b0);
    nxt;
    peek("match_clr0", 32'h7f28, 32'h0);
    drive(32'h7f24, 32'd10, 1'b1, 1'b0);
    nxt;
    drive(32'h7f20, 32'd8, 1'b1, 1'b0);
    nxt;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("cyc_8", 64'(cycles), 64'd8);
    peek("status_c8", 32'h7f28, 32'h0);
    nxt;
    check("cyc_9", 64'(cycles), 64'd9);
    nxt;
    check("cyc_10", 64'(cycles), 64'd10);
    peek("status_c10", 32'h7f28, 32'h0);
    nxt;
    peek("match_set", 32'h7f28, 32'h1);
    drive(32'h7f28, 32'h1, 1'b1, 1'b0);
    nxt;
    peek("match_clr1", 32'h7f28, 32'h0);
    drive(32'h7f20, 32'd10, 1'b1, 1'b0);
    nxt;
    check("cyc_10b", 64'(cycles), 64'd10);
    drive(32'h7f28, 32'h1, 1'b1, 1'b0);
    nxt;
    peek("set_wins", 32'h7f28, 32'h1);
    drive(32'h7f28, 32'h1, 1'b1, 1'b0);
    nxt;
    peek("match_clr2", 32'h7f28, 32'h0);

    // Input channel 1 capture and pop
    in_data = {32'habcd, 32'h0};
    in_vld  = 2'b10;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    nxt;
    in_vld = 2'b00;
    check("rdy_full1", 64'(in_rdy), 64'h1);
    peek("status_full1", 32'h7f28, 32'h4);
    drive(32'h7f44, 32'h0, 1'b0, 1'b1);
    check("in1_pop", 64'(bus_if.rdata), 64'habcd);
    nxt;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("rdy_pop1", 64'(in_rdy), 64'h3);
    peek("status_pop1", 32'h7f28, 32'h0);
    drive(32'h7f44, 32'h0, 1'b0, 1'b1);
    check("in1_stale", 64'(bus_if.rdata), 64'habcd);
    nxt;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("rdy_stale", 64'(in_rdy), 64'h3);

    // Channel 0 with valid held: no overwrite while full, no same-cycle refill
    in_data = {32'h0, 32'h55};
    in_vld  = 2'b01;
    nxt;
    check("rdy_full0", 64'(in_rdy), 64'h2);
    in_data = {32'h0, 32'h66};
    nxt;
    check("rdy_hold0", 64'(in_rdy), 64'h2);
    peek("in0_keep", 32'h7f40, 32'h55);
    drive(32'h7f40, 32'h0, 1'b0, 1'b1);
    nxt;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("no_refill", 64'(in_rdy), 64'h3);
    nxt;
    check("refill", 64'(in_rdy), 64'h2);
    in_vld = 2'b00;
    peek("in0_new", 32'h7f40, 32'h66);
    drive(32'h7f40, 32'h0, 1'b0, 1'b1);
    nxt;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("rdy_drain", 64'(in_rdy), 64'h3);

    // Interrupt enable and MATCH-driven irq (CMP is still 10)
    drive(32'h7f2c, 32'h1, 1'b1, 1'b0);
    nxt;
    peek("ie_rd", 32'h7f2c, 32'(exp_ie));
    check("hit_ie", 64'(bus_if.hit), 64'(exp_ie));
    drive(32'h7f20, 32'd9, 1'b1, 1'b0);
    nxt;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("irq_c9", 64'(irq), 64'h0);
    nxt;
    check("irq_c10", 64'(irq), 64'h0);
    nxt;
    check("irq_match", 64'(irq), 64'(exp_ie));
    peek("status_irq", 32'h7f28, 32'h1);
    drive(32'h7f28, 32'h1, 1'b1, 1'b0);
    nxt;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("irq_clr", 64'(irq), 64'h0);
    peek("status_irq_clr", 32'h7f28, 32'h0);

    // Reset during a pending handshake and a store
    in_data = {32'h77, 32'h0};
    in_vld  = 2'b10;
    rst     = 1'b1;
    drive(32'h7f00, 32'h9, 1'b1, 1'b0);
    nxt;
    rst    = 1'b0;
    in_vld = 2'b00;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("rdy_rst2", 64'(in_rdy), 64'h3);
    check("out_bus_rst2", out_bus, 64'h0);
    check("cycles_rst2", 64'(cycles), 64'h0);
    check("irq_rst2", 64'(irq), 64'h0);
    peek("cmp_rst2", 32'h7f24, 32'hffff_ffff);
    peek("status_rst2", 32'h7f28, 32'h0);
    peek("in1_rst2", 32'h7f44, 32'h0);
    peek("ie_rst2", 32'h7f2c, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
